// File: rtl/alu_wb_sched_pkg.sv
// Shared types and helpers for the ALU write-back scheduler: unit classes,
// per-class latency and the one-hot unit encoding.
package alu_wb_sched_pkg;

    typedef enum logic [2:0] {
        CLS_ADDSUB  = 3'd0,
        CLS_SHIFT   = 3'd1,
        CLS_LOGIC   = 3'd2,
        CLS_MULHI   = 3'd3,
        CLS_MULLO   = 3'd4,
        CLS_COM     = 3'd5,
        CLS_MAC     = 3'd6,
        CLS_ILLEGAL = 3'd7
    } alu_class_e;

    localparam int ALU_NUM_UNITS = 7;

    function automatic int class_lat(input alu_class_e cls, input int mul_lat, input int mac_lat);
        case (cls)
            CLS_MULHI, CLS_MULLO: class_lat = mul_lat;
            CLS_MAC:              class_lat = mac_lat;
            default:              class_lat = 1;
        endcase
    endfunction

    // The illegal class maps to no unit at all.
    function automatic logic [ALU_NUM_UNITS-1:0] class_onehot(input alu_class_e cls);
        case (cls)
            CLS_ADDSUB: class_onehot = 7'b0000001;
            CLS_SHIFT:  class_onehot = 7'b0000010;
            CLS_LOGIC:  class_onehot = 7'b0000100;
            CLS_MULHI:  class_onehot = 7'b0001000;
            CLS_MULLO:  class_onehot = 7'b0010000;
            CLS_COM:    class_onehot = 7'b0100000;
            CLS_MAC:    class_onehot = 7'b1000000;
            default:    class_onehot = 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/alu_wb_reservation.sv
// Write-back slot shift register. Slot k holds the result due k cycles from now.
// Provides one write port, an occupancy query and the head entry.
module alu_wb_reservation
    import alu_wb_sched_pkg::*;
#(
    parameter int MAX_LAT = 4,
    parameter int TAG_W   = 4,
    parameter int IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [2:0]       wr_class,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [IDX_W-1:0] query_idx,
    output logic             query_busy,
    output logic             head_valid,
    output logic [2:0]       head_class,
    output logic [TAG_W-1:0] head_tag,
    output logic             busy
);

    logic [MAX_LAT-1:0] valid_r;
    logic [2:0]         class_r [MAX_LAT];
    logic [TAG_W-1:0]   tag_r   [MAX_LAT];

    logic [MAX_LAT-1:0] up_valid_s;
    logic [2:0]         up_class_s [MAX_LAT];
    logic [TAG_W-1:0]   up_tag_s   [MAX_LAT];

    // Each slot's shifted-in value; the top slot always receives an empty entry.
    for (genvar g = 0; g < MAX_LAT; g++) begin : g_shift
        if (g == MAX_LAT - 1) begin : g_top
            assign up_valid_s[g] = 1'b0;
            assign up_class_s[g] = 3'd0;
            assign up_tag_s[g]   = '0;
        end else begin : g_mid
            assign up_valid_s[g] = valid_r[g+1];
            assign up_class_s[g] = class_r[g+1];
            assign up_tag_s[g]   = tag_r[g+1];
        end
    end

    // Slot register: clear on reset/flush, otherwise shift down and apply the write.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_r <= '0;
            for (int i = 0; i < MAX_LAT; i++) begin
                class_r[i] <= 3'd0;
                tag_r[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_LAT; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    valid_r[i] <= 1'b1;
                    class_r[i] <= wr_class;
                    tag_r[i]   <= wr_tag;
                end else begin
                    valid_r[i] <= up_valid_s[i];
                    class_r[i] <= up_class_s[i];
                    tag_r[i]   <= up_tag_s[i];
                end
            end
        end
    end

    // Occupancy lookup; an index of MAX_LAT lies beyond the register and reads as free.
    always_comb begin
        query_busy = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (query_idx == IDX_W'(i)) begin
                query_busy = valid_r[i];
            end else begin
                query_busy = query_busy;
            end
        end
    end

    assign head_valid = valid_r[0];
    assign head_class = class_r[0];
    assign head_tag   = tag_r[0];
    assign busy       = |valid_r;

endmodule

// File: rtl/alu_wb_scheduler.sv
// ALU write-back scheduler: issue handshake, latency-based slot reservation and result-mux select decode.
// Optional macro ALU_WB_SCHED_PERF_EN adds a saturating issue-stall counter output.
module alu_wb_scheduler
    import alu_wb_sched_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 3,
    parameter int MAC_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [2:0]       issue_class_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    input  logic             flush_i,
    output logic [6:0]       fu_start_o,
    output logic             addsub_sel_o,
    output logic             shift_sel_o,
    output logic             logic_sel_o,
    output logic             mul_sel_hi_o,
    output logic             mul_sel_low_o,
    output logic             com_sel_o,
    output logic             mac_sel_o,
    output logic             wb_valid_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic             illegal_o,
`ifdef ALU_WB_SCHED_PERF_EN
    output logic [15:0]      stall_cnt_o,
`endif
    output logic             busy_o
);

    localparam int MUL_MAC_MAX = (MUL_LAT > MAC_LAT) ? MUL_LAT : MAC_LAT;
    localparam int MAX_LAT     = (MUL_MAC_MAX > 1) ? MUL_MAC_MAX : 1;
    localparam int IDX_W       = $clog2(MAX_LAT + 1);

    alu_class_e                   cls_s;
    logic [IDX_W-1:0]             lat_s;
    logic [IDX_W-1:0]             wr_idx_s;
    logic                         slot_busy_s;
    logic                         ready_s;
    logic                         accept_s;
    logic                         reserve_s;
    logic                         head_valid_s;
    logic [2:0]                   head_class_s;
    logic [TAG_W-1:0]             head_tag_s;
    logic                         any_busy_s;
    logic [ALU_NUM_UNITS-1:0]     sel_s;
    logic [TAG_W-1:0]             tag_s;
    logic [ALU_NUM_UNITS-1:0]     start_s;
    logic                         illegal_r;

    assign cls_s     = alu_class_e'(issue_class_i);
    assign lat_s     = IDX_W'(class_lat(cls_s, MUL_LAT, MAC_LAT));
    assign wr_idx_s  = lat_s - IDX_W'(1);
    assign accept_s  = issue_valid_i && ready_s;
    assign reserve_s = accept_s && (cls_s != CLS_ILLEGAL);

    // Accept when the slot the op would land in is still free as it shifts down.
    always_comb begin
        ready_s = 1'b0;
        if (flush_i) begin
            ready_s = 1'b0;
        end else if (cls_s == CLS_ILLEGAL) begin
            ready_s = 1'b1;
        end else if (lat_s == IDX_W'(MAX_LAT)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = !slot_busy_s;
        end
    end

    // Unit start strobe in the issue cycle.
    always_comb begin
        start_s = 7'b0000000;
        if (accept_s) begin
            start_s = class_onehot(cls_s);
        end else begin
            start_s = 7'b0000000;
        end
    end

    alu_wb_reservation #(
        .MAX_LAT (MAX_LAT),
        .TAG_W   (TAG_W),
        .IDX_W   (IDX_W)
    ) u_resv (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (flush_i),
        .wr_en      (reserve_s),
        .wr_idx     (wr_idx_s),
        .wr_class   (issue_class_i),
        .wr_tag     (issue_tag_i),
        .query_idx  (lat_s),
        .query_busy (slot_busy_s),
        .head_valid (head_valid_s),
        .head_class (head_class_s),
        .head_tag   (head_tag_s),
        .busy       (any_busy_s)
    );

    // Result-mux select and tag decoded from the head slot.
    always_comb begin
        sel_s = 7'b0000000;
        tag_s = '0;
        if (head_valid_s) begin
            sel_s = class_onehot(alu_class_e'(head_class_s));
            tag_s = head_tag_s;
        end else begin
            sel_s = 7'b0000000;
            tag_s = '0;
        end
    end

    // Illegal-class pulse, one cycle after the discard.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= accept_s && (cls_s == CLS_ILLEGAL);
        end
    end

`ifdef ALU_WB_SCHED_PERF_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles an offered op was held back by a busy slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= 16'h0000;
        end else if (issue_valid_i && !ready_s && !flush_i && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`endif

    assign issue_ready_o = ready_s;
    assign fu_start_o    = start_s;
    assign addsub_sel_o  = sel_s[0];
    assign shift_sel_o   = sel_s[1];
    assign logic_sel_o   = sel_s[2];
    assign mul_sel_hi_o  = sel_s[3];
    assign mul_sel_low_o = sel_s[4];
    assign com_sel_o     = sel_s[5];
    assign mac_sel_o     = sel_s[6];
    assign wb_valid_o    = |sel_s;
    assign wb_tag_o      = tag_s;
    assign illegal_o     = illegal_r;
    assign busy_o        = any_busy_s;

endmodule

// File: tb/tb_alu_wb_scheduler.sv
// Self-checking bench for alu_wb_scheduler: a per-cycle result calendar model plus directed vectors.
module tb_alu_wb_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_class;
    logic [3:0] issue_tag;
    logic       flush;
    logic [6:0] fu_start;
    logic       addsub_sel, shift_sel, logic_sel, mul_sel_hi, mul_sel_low, com_sel, mac_sel;
    logic       wb_valid;
    logic [3:0] wb_tag;
    logic       illegal;
    logic       busy;
`ifdef ALU_WB_SCHED_PERF_EN
    logic [15:0] stall_cnt;
`endif

    alu_wb_scheduler dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_class_i (issue_class),
        .issue_tag_i   (issue_tag),
        .flush_i       (flush),
        .fu_start_o    (fu_start),
        .addsub_sel_o  (addsub_sel),
        .shift_sel_o   (shift_sel),
        .logic_sel_o   (logic_sel),
        .mul_sel_hi_o  (mul_sel_hi),
        .mul_sel_low_o (mul_sel_low),
        .com_sel_o     (com_sel),
        .mac_sel_o     (mac_sel),
        .wb_valid_o    (wb_valid),
        .wb_tag_o      (wb_tag),
        .illegal_o     (illegal),
`ifdef ALU_WB_SCHED_PERF_EN
        .stall_cnt_o   (stall_cnt),
`endif
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Model: calendar of results indexed by the absolute cycle they appear in.
    bit         sched_v   [0:1023];
    logic [2:0] sched_cls [0:1023];
    logic [3:0] sched_tag [0:1023];
    bit         ill_exp   [0:1023];
    int         m_stall   = 0;

    int         e_lat;
    logic       e_ready;
    logic [6:0] e_start;
    logic [6:0] e_sel;
    logic [3:0] e_tag;
    logic       e_busy;
    logic [6:0] a_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [2:0] c);
        if (c == 3'd3 || c == 3'd4) return 3;
        if (c == 3'd6) return 4;
        return 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare every cycle against the calendar, then commit this cycle's inputs to it.
    always @(negedge clk) begin
        if (chk_en) begin
            e_lat   = lat_of(issue_class);
            e_ready = !flush && (issue_class == 3'd7 || !sched_v[cyc + e_lat]);
            e_start = 7'b0;
            if (issue_valid && e_ready && issue_class != 3'd7) e_start[issue_class] = 1'b1;
            e_sel = 7'b0;
            e_tag = 4'h0;
            if (sched_v[cyc]) begin
                e_sel[sched_cls[cyc]] = 1'b1;
                e_tag = sched_tag[cyc];
            end
            e_busy = 1'b0;
            for (int k = 0; k < 4; k++) e_busy = e_busy | sched_v[cyc + k];
            a_sel = {mac_sel, com_sel, mul_sel_low, mul_sel_hi, logic_sel, shift_sel, addsub_sel};

            chk("m_ready",   32'(issue_ready), 32'(e_ready));
            chk("m_start",   32'(fu_start),    32'(e_start));
            chk("m_sel",     32'(a_sel),       32'(e_sel));
            chk("m_wbvalid", 32'(wb_valid),    32'(sched_v[cyc]));
            chk("m_wbtag",   32'(wb_tag),      32'(e_tag));
            chk("m_illegal", 32'(illegal),     32'(ill_exp[cyc]));
            chk("m_busy",    32'(busy),        32'(e_busy));
`ifdef ALU_WB_SCHED_PERF_EN
            chk("m_stall",   32'(stall_cnt),   32'(m_stall));
`endif
            if (rst) begin
                for (int k = 1; k < 9; k++) begin
                    sched_v[cyc + k] = 1'b0;
                    ill_exp[cyc + k] = 1'b0;
                end
                m_stall = 0;
            end else begin
                if (issue_valid && !e_ready && !flush && m_stall != 65535) m_stall++;
                if (flush) begin
                    for (int k = 1; k < 9; k++) sched_v[cyc + k] = 1'b0;
                end else if (issue_valid && e_ready) begin
                    if (issue_class == 3'd7) begin
                        ill_exp[cyc + 1] = 1'b1;
                    end else begin
                        sched_v[cyc + e_lat]   = 1'b1;
                        sched_cls[cyc + e_lat] = issue_class;
                        sched_tag[cyc + e_lat] = issue_tag;
                    end
                end
            end
        end
    end

    // Advance one cycle and drive that cycle's inputs.
    task automatic step(input logic v, input logic [2:0] c, input logic [3:0] t,
                        input logic f, input logic r);
        @(posedge clk);
        #1;
        issue_valid = v;
        issue_class = c;
        issue_tag   = t;
        flush       = f;
        rst         = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_class = 3'd0; issue_tag = 4'h0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("rst_wbvalid", 32'(wb_valid), 32'd0);
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_ready",   32'(issue_ready), 32'd1);
        chk("rst_illegal", 32'(illegal),  32'd0);

        // ADDSUB single-cycle op
        step(1'b1, 3'd0, 4'd3, 1'b0, 1'b0); #2;
        chk("t1_start", 32'(fu_start), 32'b0000001);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("t1_sel", 32'(addsub_sel), 32'd1);
        chk("t1_wbvalid", 32'(wb_valid), 32'd1);
        chk("t1_tag", 32'(wb_tag), 32'd3);
        idle(3);

        // MAC then MULLO collision, retried
        step(1'b1, 3'd6, 4'd1, 1'b0, 1'b0);
        step(1'b1, 3'd4, 4'd2, 1'b0, 1'b0); #2;
        chk("t2_refuse", 32'(issue_ready), 32'd0);
        step(1'b1, 3'd4, 4'd2, 1'b0, 1'b0); #2;
        chk("t2_accept", 32'(issue_ready), 32'd1);
        idle(1);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("t2_mac", 32'(mac_sel), 32'd1);
        chk("t2_mactag", 32'(wb_tag), 32'd1);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("t2_mullo", 32'(mul_sel_low), 32'd1);
        chk("t2_mullotag", 32'(wb_tag), 32'd2);
        idle(3);

        // Short op overtakes a long one
        step(1'b1, 3'd3, 4'd5, 1'b0, 1'b0);
        step(1'b1, 3'd2, 4'd6, 1'b0, 1'b0);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("t3_logic", 32'(logic_sel), 32'd1);
        chk("t3_logictag", 32'(wb_tag), 32'd6);
        chk("t3_nohi", 32'(mul_sel_hi), 32'd0);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("t3_hi", 32'(mul_sel_hi), 32'd1);
        chk("t3_hitag", 32'(wb_tag), 32'd5);
        idle(3);

        // Back-to-back SHIFT stream
        for (int i = 0; i < 9; i++) begin
            step(i < 8, 3'd1, 4'(i + 8), 1'b0, 1'b0); #2;
            if (i < 8) chk("t4_ready", 32'(issue_ready), 32'd1);
            if (i > 0) begin
                chk("t4_sel", 32'(shift_sel), 32'd1);
                chk("t4_tag", 32'(wb_tag), 32'(i + 7));
            end
        end
        idle(3);

        // Flush kills an in-flight MAC
        step(1'b1, 3'd6, 4'd9, 1'b0, 1'b0);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 4'd4, 1'b1, 1'b0); #2;
        chk("t5_ready", 32'(issue_ready), 32'd0);
        chk("t5_busy_before", 32'(busy), 32'd1);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("t5_busy_after", 32'(busy), 32'd0);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("t5_nomac", 32'(mac_sel), 32'd0);
        idle(2);

        // Flush in the same cycle as a write-back
        step(1'b1, 3'd5, 4'd7, 1'b0, 1'b0);
        step(1'b0, 3'd0, 4'd0, 1'b1, 1'b0); #2;
        chk("tf_com", 32'(com_sel), 32'd1);
        chk("tf_tag", 32'(wb_tag), 32'd7);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("tf_after", 32'(wb_valid), 32'd0);
        idle(2);

        // Illegal class
        step(1'b1, 3'd7, 4'd4, 1'b0, 1'b0); #2;
        chk("t6_ready", 32'(issue_ready), 32'd1);
        chk("t6_start", 32'(fu_start), 32'd0);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("t6_illegal", 32'(illegal), 32'd1);
        chk("t6_wbvalid", 32'(wb_valid), 32'd0);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("t6_pulse", 32'(illegal), 32'd0);
        idle(2);

        // Reset mid-operation drops in-flight work silently
        step(1'b1, 3'd6, 4'd2, 1'b0, 1'b0);
        step(1'b1, 3'd7, 4'd3, 1'b0, 1'b1);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0); #2;
        chk("tr_busy", 32'(busy), 32'd0);
        chk("tr_illegal", 32'(illegal), 32'd0);
        idle(5);

`ifdef ALU_WB_SCHED_PERF_EN
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 3'd6, 4'(r), 1'b0, 1'b0);
            step(1'b1, 3'd4, 4'(r + 4), 1'b0, 1'b0);
            step(1'b1, 3'd4, 4'(r + 4), 1'b0, 1'b0);
            idle(3);
        end
        #2 chk("tp_stall", 32'(stall_cnt), 32'd3);
        idle(2);
`endif

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
